core_mem_sched: RTL and testbench
=================================

Name: core_mem_sched

Overview:
- Sequencer that lets the single-cycle RV32I core share one single-ported RAM between instruction fetch, load and store.
- Drives the core's clk_en so that exactly one instruction retires per step: fetch word, then the optional data access, then a one-cycle clk_en pulse.
- Sits between the core's fetch/read/write ports and the RAM's req/gnt/rvalid port; also provides run/single-step control and a retired-instruction counter.

Parameters:
- ADDR_WIDTH, 31, MSB index of all address buses (bus width is ADDR_WIDTH+1).
- DATA_WIDTH, 31, MSB index of all data buses (bus width is DATA_WIDTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_run  in  1  free-run: start a new step after every completed step.
- i_step  in  1  one-cycle pulse: execute one instruction from IDLE.
- o_core_clk_en  out  1  core clock enable; high for exactly one cycle per retired instruction.
- i_core_fetch_addr  in  ADDR_WIDTH+1  core fetch address (o_read_fetch_addr).
- o_core_fetch_data  out  DATA_WIDTH+1  buffered instruction word to the core.
- i_core_read_req  in  1  core data-read request.
- i_core_read_addr  in  ADDR_WIDTH+1  core data-read address.
- o_core_read_data  out  DATA_WIDTH+1  buffered load data to the core.
- i_core_write_enable  in  1  core store request.
- i_core_byte_enable  in  4  store byte lanes.
- i_core_write_addr  in  ADDR_WIDTH+1  store address.
- i_core_write_data  in  DATA_WIDTH+1  store data.
- o_mem_req  out  1  RAM request valid.
- i_mem_gnt  in  1  RAM accepts the request this cycle.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_be  out  4  byte enables; 4'b1111 on reads.
- o_mem_addr  out  ADDR_WIDTH+1  RAM address.
- o_mem_wdata  out  DATA_WIDTH+1  RAM write data.
- i_mem_rvalid  in  1  read data valid; at least 1 cycle after gnt.
- i_mem_rdata  in  DATA_WIDTH+1  read data.
- o_busy  out  1  high in any state other than IDLE.
- o_retired  out  32  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; fetch and read buffers 0; o_retired 0. Reset mid-access abandons the access. An rvalid arriving after reset is ignored.
- States: IDLE, F_REQ, F_WAIT, EXEC, R_REQ, R_WAIT, W_REQ, STEP.
- IDLE: go to F_REQ if i_run or i_step. An i_step pulse in any other state is ignored.
- F_REQ: o_mem_req=1, we=0, addr=i_core_fetch_addr. On gnt, go to F_WAIT.
- F_WAIT: on rvalid, capture rdata into the fetch buffer and go to EXEC.
- EXEC: the core decodes the buffered instruction combinationally.
  - If i_core_write_enable, go to W_REQ. Write has priority; a simultaneous read_req is dropped.
  - Else if i_core_read_req, go to R_REQ.
  - Else go to STEP.
- R_REQ: read at i_core_read_addr; on gnt, go to R_WAIT.
- R_WAIT: on rvalid, capture into the read buffer and go to STEP.
- W_REQ: o_mem_req=1, we=1, be/addr/wdata from the core. On gnt, go to STEP. No rvalid is expected for writes.
- STEP: o_core_clk_en=1 for this cycle only; o_retired+1, wrapping 0xFFFFFFFF→0. Next state is F_REQ if i_run, else IDLE.
- Request stability: while o_mem_req=1 and gnt=0, o_mem_we/be/addr/wdata hold stable. At most one transaction is outstanding.
- Spurious rvalid: ignored outside F_WAIT and R_WAIT.
- Buffer stability: the fetch and read buffers hold from capture through STEP. Core inputs are therefore stable at the clk_en edge.
- Deasserting i_run mid-step: the current step completes, then the block enters IDLE.
- Latency with gnt=1 and rvalid one cycle after gnt: ALU/LUI step 4 cycles, store 5, load 6.
- Addresses and data pass through unmodified; there is no lane shifting.

Decomposition:
- Package core_sched_pkg: state enum sched_state_t, the BE_ALL constant (4'b1111).
- Sub-module sched_mem_if: the req/gnt/rvalid single-outstanding transaction tracker. Interface: start, write flag, accepted, data_valid.

Test Plan:
- i_step pulse, RAM[0]=0x00500093 (addi x1,x0,5), gnt=1, rvalid +1 cycle → fetch at addr 0; clk_en pulses once at cycle 4; o_retired=1; then IDLE.
- Load lw with read_req, read addr 0x10, RAM returns 0xDEADBEEF → read access follows the fetch; o_core_read_data=0xDEADBEEF at clk_en; step takes 6 cycles.
- Store sb with write_enable, be=4'b0001, addr 0x20, wdata 0x000000AB → a single write with we=1 and be=0001; no read; clk_en at cycle 5.
- gnt held 0 for 3 cycles in F_REQ → req/addr stable every cycle; transition only on the gnt cycle; spurious rvalid during F_REQ is ignored.
- i_run=1 for 3 steps, o_retired preset to 0xFFFFFFFE → counter goes FFFFFFFF, 0, 1; clk_en pulses are separated by at least 3 cycles.
- Reset asserted in R_WAIT, then rvalid arrives → all outputs 0; state IDLE; rvalid ignored; no clk_en pulse.

Source files
------------

// File: rtl/core_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : core_sched_pkg
// Purpose  : Shared state encoding and constants for the core memory scheduler.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package core_sched_pkg;

  // All four byte lanes; every read is a full-word access.
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_REQ  = 3'd1,
    F_WAIT = 3'd2,
    EXEC   = 3'd3,
    R_REQ  = 3'd4,
    R_WAIT = 3'd5,
    W_REQ  = 3'd6,
    STEP   = 3'd7
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sched_mem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sched_mem_if
// Purpose  : Single-outstanding req/gnt/rvalid transaction tracker. A read is
//            pending from its grant until rvalid; rvalid with nothing pending
//            is discarded, so stray responses never reach the sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module sched_mem_if (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_write,
  input  logic i_mem_gnt,
  input  logic i_mem_rvalid,
  output logic o_mem_req,
  output logic o_accepted,
  output logic o_data_valid
);

  logic r_pending;

  // A new request is only presented once any earlier read has completed.
  assign o_mem_req    = i_start & ~r_pending;
  assign o_accepted   = o_mem_req & i_mem_gnt;
  assign o_data_valid = r_pending & i_mem_rvalid;

  // Track the one outstanding read; writes complete at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (o_accepted && !i_write) begin
      r_pending <= 1'b1;
    end else if (i_mem_rvalid) begin
      r_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : core_mem_sched
// Purpose  : Shares one single-ported RAM between fetch, load and store of a
//            single-cycle core, retiring one instruction per clk_en pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module core_mem_sched
  import core_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_step,
  output logic                  o_core_clk_en,
  input  logic [ADDR_WIDTH:0]   i_core_fetch_addr,
  output logic [DATA_WIDTH:0]   o_core_fetch_data,
  input  logic                  i_core_read_req,
  input  logic [ADDR_WIDTH:0]   i_core_read_addr,
  output logic [DATA_WIDTH:0]   o_core_read_data,
  input  logic                  i_core_write_enable,
  input  logic [3:0]            i_core_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_core_write_addr,
  input  logic [DATA_WIDTH:0]   i_core_write_data,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH:0]   i_mem_rdata,
  output logic                  o_busy,
  output logic [31:0]           o_retired
);

  sched_state_t              r_state;
  sched_state_t              w_next;
  logic                      w_start;
  logic                      w_we;
  logic [3:0]                w_be;
  logic [ADDR_WIDTH:0]       w_addr;
  logic [DATA_WIDTH:0]       w_wdata;
  logic                      w_accepted;
  logic                      w_data_valid;
  logic [DATA_WIDTH:0]       r_fetch_buf;
  logic [DATA_WIDTH:0]       r_read_buf;
  logic [31:0]               r_retired;

  sched_mem_if u_mem_if (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_write      (w_we),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .o_mem_req    (o_mem_req),
    .o_accepted   (w_accepted),
    .o_data_valid (w_data_valid)
  );

  // Request fields come straight from the gated core, so they stay stable
  // for as long as the request waits for a grant.
  always_comb begin
    w_start = 1'b0;
    w_we    = 1'b0;
    w_be    = 4'b0000;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      F_REQ: begin
        w_start = 1'b1;
        w_be    = BE_ALL;
        w_addr  = i_core_fetch_addr;
      end
      R_REQ: begin
        w_start = 1'b1;
        w_be    = BE_ALL;
        w_addr  = i_core_read_addr;
      end
      W_REQ: begin
        w_start = 1'b1;
        w_we    = 1'b1;
        w_be    = i_core_byte_enable;
        w_addr  = i_core_write_addr;
        w_wdata = i_core_write_data;
      end
      default: ;
    endcase
  end

  // Step sequencing; a store wins over a simultaneous load request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_run || i_step) w_next = F_REQ;
      F_REQ:   if (w_accepted) w_next = F_WAIT;
      F_WAIT:  if (w_data_valid) w_next = EXEC;
      EXEC: begin
        if (i_core_write_enable)  w_next = W_REQ;
        else if (i_core_read_req) w_next = R_REQ;
        else                      w_next = STEP;
      end
      R_REQ:   if (w_accepted) w_next = R_WAIT;
      R_WAIT:  if (w_data_valid) w_next = STEP;
      W_REQ:   if (w_accepted) w_next = STEP;
      STEP:    w_next = i_run ? F_REQ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Capture instruction and load data; both hold until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_buf <= '0;
      r_read_buf  <= '0;
    end else begin
      if (r_state == F_WAIT && w_data_valid) r_fetch_buf <= i_mem_rdata;
      if (r_state == R_WAIT && w_data_valid) r_read_buf  <= i_mem_rdata;
    end
  end

  // Count retired instructions, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_retired <= 32'd0;
    else if (r_state == STEP) r_retired <= r_retired + 32'd1;
  end

  assign o_mem_we          = w_we;
  assign o_mem_be          = w_be;
  assign o_mem_addr        = w_addr;
  assign o_mem_wdata       = w_wdata;
  assign o_core_clk_en     = (r_state == STEP);
  assign o_busy            = (r_state != IDLE);
  assign o_core_fetch_data = r_fetch_buf;
  assign o_core_read_data  = r_read_buf;
  assign o_retired         = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_core_mem_sched
// Purpose  : Directed self-checking bench for core_mem_sched with a small
//            RAM responder (rvalid one cycle after a read grant).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_core_mem_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run, i_step;
  logic        o_core_clk_en;
  logic [31:0] i_core_fetch_addr, o_core_fetch_data;
  logic        i_core_read_req;
  logic [31:0] i_core_read_addr, o_core_read_data;
  logic        i_core_write_enable;
  logic [3:0]  i_core_byte_enable;
  logic [31:0] i_core_write_addr, i_core_write_data;
  logic        o_mem_req, i_mem_gnt, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic [31:0] o_retired;

  // Responder state
  logic        gnt_en, rv_inject, rv_resp;
  logic [31:0] rdata_resp;
  int          rd_cnt, wr_cnt;
  logic [3:0]  last_be;
  logic [31:0] last_waddr, last_wdata;

  int checks = 0;
  int errors = 0;

  assign i_mem_gnt    = gnt_en;
  assign i_mem_rvalid = rv_resp | rv_inject;
  assign i_mem_rdata  = rv_inject ? 32'hBAD0_BAD0 : rdata_resp;

  core_mem_sched #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_run               (i_run),
    .i_step              (i_step),
    .o_core_clk_en       (o_core_clk_en),
    .i_core_fetch_addr   (i_core_fetch_addr),
    .o_core_fetch_data   (o_core_fetch_data),
    .i_core_read_req     (i_core_read_req),
    .i_core_read_addr    (i_core_read_addr),
    .o_core_read_data    (o_core_read_data),
    .i_core_write_enable (i_core_write_enable),
    .i_core_byte_enable  (i_core_byte_enable),
    .i_core_write_addr   (i_core_write_addr),
    .i_core_write_data   (i_core_write_data),
    .o_mem_req           (o_mem_req),
    .i_mem_gnt           (i_mem_gnt),
    .o_mem_we            (o_mem_we),
    .o_mem_be            (o_mem_be),
    .o_mem_addr          (o_mem_addr),
    .o_mem_wdata         (o_mem_wdata),
    .i_mem_rvalid        (i_mem_rvalid),
    .i_mem_rdata         (i_mem_rdata),
    .o_busy              (o_busy),
    .o_retired           (o_retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // RAM model: read data one cycle after grant; log every write.
  always @(posedge clk) begin
    rv_resp <= 1'b0;
    if (o_mem_req && i_mem_gnt) begin
      if (o_mem_we) begin
        wr_cnt     <= wr_cnt + 1;
        last_be    <= o_mem_be;
        last_waddr <= o_mem_addr;
        last_wdata <= o_mem_wdata;
      end else begin
        rd_cnt     <= rd_cnt + 1;
        rv_resp    <= 1'b1;
        rdata_resp <= ram_word(o_mem_addr);
      end
    end
  end

  // Pulse i_step from IDLE and count negedges until clk_en (F_REQ is 1).
  task automatic step_and_count(output int n);
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    n = 1;
    while (!o_core_clk_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_core_clk_en) n = -1;
  endtask

  task automatic set_core(input logic rd, input logic [31:0] raddr, input logic wr,
                          input logic [3:0] be, input logic [31:0] waddr,
                          input logic [31:0] wdata, input logic [31:0] faddr);
    i_core_read_req     = rd;
    i_core_read_addr    = raddr;
    i_core_write_enable = wr;
    i_core_byte_enable  = be;
    i_core_write_addr   = waddr;
    i_core_write_data   = wdata;
    i_core_fetch_addr   = faddr;
  endtask

  task automatic test_reset;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    checks++; if (o_core_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %0b want 0", o_core_clk_en); end
    checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_be !== 4'b0)
      begin errors++; $display("FAIL reset_mem_ctl got req=%0b we=%0b be=%h want 0", o_mem_req, o_mem_we, o_mem_be); end
    checks++; if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", o_mem_addr, o_mem_wdata); end
    checks++; if (o_retired !== 32'h0) begin errors++; $display("FAIL reset_retired got %h want 0", o_retired); end
    checks++; if (o_core_fetch_data !== 32'h0 || o_core_read_data !== 32'h0)
      begin errors++; $display("FAIL reset_buffers got %h/%h want 0", o_core_fetch_data, o_core_read_data); end
  endtask

  task automatic test_alu_step;
    int n;
    int rd0;
    set_core(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    gnt_en = 1'b1;
    rd0 = rd_cnt;
    step_and_count(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL alu_latency got %0d want 4", n); end
    checks++; if (o_core_fetch_data !== 32'h0050_0093) begin errors++; $display("FAIL alu_fetch_data got %h want 00500093", o_core_fetch_data); end
    @(negedge clk);
    checks++; if (o_retired !== 32'd1) begin errors++; $display("FAIL alu_retired got %0d want 1", o_retired); end
    checks++; if (o_busy !== 1'b0 || o_core_clk_en !== 1'b0)
      begin errors++; $display("FAIL alu_idle got busy=%0b clk_en=%0b want 0/0", o_busy, o_core_clk_en); end
    checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL alu_reads got %0d want 1", rd_cnt - rd0); end
  endtask

  task automatic test_load;
    int n;
    int rd0, wr0;
    set_core(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 32'h4);
    rd0 = rd_cnt; wr0 = wr_cnt;
    step_and_count(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL load_latency got %0d want 6", n); end
    checks++; if (o_core_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", o_core_read_data); end
    checks++; if (o_core_fetch_data !== 32'h5A5A_0004) begin errors++; $display("FAIL load_fetch got %h want 5a5a0004", o_core_fetch_data); end
    @(negedge clk);
    checks++; if (rd_cnt - rd0 !== 2 || wr_cnt - wr0 !== 0)
      begin errors++; $display("FAIL load_accesses got rd=%0d wr=%0d want 2/0", rd_cnt - rd0, wr_cnt - wr0); end
    checks++; if (o_retired !== 32'd2) begin errors++; $display("FAIL load_retired got %0d want 2", o_retired); end
  endtask

  task automatic test_store;
    int n;
    int rd0, wr0;
    // read_req asserted too: the store must win and the load be dropped
    set_core(1'b1, 32'h10, 1'b1, 4'b0001, 32'h20, 32'h0000_00AB, 32'h8);
    rd0 = rd_cnt; wr0 = wr_cnt;
    step_and_count(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL store_latency got %0d want 5", n); end
    @(negedge clk);
    checks++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 1)
      begin errors++; $display("FAIL store_accesses got wr=%0d rd=%0d want 1/1", wr_cnt - wr0, rd_cnt - rd0); end
    checks++; if (last_be !== 4'b0001) begin errors++; $display("FAIL store_be got %b want 0001", last_be); end
    checks++; if (last_waddr !== 32'h20) begin errors++; $display("FAIL store_addr got %h want 20", last_waddr); end
    checks++; if (last_wdata !== 32'hAB) begin errors++; $display("FAIL store_wdata got %h want ab", last_wdata); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL store_idle got busy=%0b want 0", o_busy); end
  endtask

  task automatic test_gnt_stall;
    int n;
    set_core(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h8);
    gnt_en = 1'b0;
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) rv_inject = 1'b1;
      checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8 || o_mem_we !== 1'b0 || o_mem_be !== 4'hF)
        begin errors++; $display("FAIL stall_req_%0d got req=%0b addr=%h we=%0b be=%h want 1/8/0/f", k, o_mem_req, o_mem_addr, o_mem_we, o_mem_be); end
      @(negedge clk);
      rv_inject = 1'b0;
    end
    checks++; if (o_mem_req !== 1'b1 || o_busy !== 1'b1)
      begin errors++; $display("FAIL stall_hold got req=%0b busy=%0b want 1/1", o_mem_req, o_busy); end
    gnt_en = 1'b1;
    @(negedge clk);
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL stall_after_gnt got req=%0b want 0", o_mem_req); end
    n = 0;
    while (!o_core_clk_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL stall_tail got %0d want 2", n); end
    checks++; if (o_core_fetch_data !== 32'h5A5A_0008) begin errors++; $display("FAIL stall_fetch got %h want 5a5a0008", o_core_fetch_data); end
    @(negedge clk);
  endtask

  task automatic test_run_wrap;
    logic [31:0] exp_ret [3];
    int pulses, last, t;
    exp_ret[0] = 32'hFFFF_FFFF; exp_ret[1] = 32'h0; exp_ret[2] = 32'h1;
    set_core(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    force dut.r_retired = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_retired;
    i_run = 1'b1;
    pulses = 0; last = 0; t = 0;
    while (pulses < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (o_core_clk_en) begin
        if (pulses > 0) begin
          checks++; if (t - last !== 4) begin errors++; $display("FAIL run_gap_%0d got %0d want 4", pulses, t - last); end
        end
        last = t;
        pulses++;
        if (pulses == 3) i_run = 1'b0;
        @(negedge clk);
        t++;
        checks++; if (o_retired !== exp_ret[pulses-1])
          begin errors++; $display("FAIL run_retired_%0d got %h want %h", pulses, o_retired, exp_ret[pulses-1]); end
      end
    end
    i_run = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL run_pulses got %0d want 3", pulses); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL run_stop got busy=%0b want 0", o_busy); end
  endtask

  task automatic test_reset_mid_read;
    int seen;
    set_core(1'b1, 32'h14, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    gnt_en = 1'b1;
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (o_busy !== 1'b1 || o_mem_req !== 1'b0 || i_mem_rvalid !== 1'b1)
      begin errors++; $display("FAIL rmid_in_rwait got busy=%0b req=%0b rvalid=%0b want 1/0/1", o_busy, o_mem_req, i_mem_rvalid); end
    rst = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_retired !== 32'h0 || o_core_clk_en !== 1'b0)
      begin errors++; $display("FAIL rmid_async got busy=%0b ret=%h clk_en=%0b want 0", o_busy, o_retired, o_core_clk_en); end
    checks++; if (o_core_fetch_data !== 32'h0 || o_core_read_data !== 32'h0)
      begin errors++; $display("FAIL rmid_buffers got %h/%h want 0", o_core_fetch_data, o_core_read_data); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_core_clk_en || o_busy || o_mem_req) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles want 0", seen); end
    checks++; if (o_core_read_data !== 32'h0 || o_retired !== 32'h0)
      begin errors++; $display("FAIL rmid_after got rdata=%h ret=%h want 0/0", o_core_read_data, o_retired); end
  endtask

  initial begin
    rst = 1'b0; i_run = 1'b0; i_step = 1'b0;
    gnt_en = 1'b1; rv_inject = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    set_core(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_alu_step;
    test_load;
    test_store;
    test_gnt_stall;
    test_run_wrap;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
